// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences every work-RAM access for the CPU and host ports, one grant at a time.
// Build with `define MEM_ARBITER_STATS_EN to add the cpu/host wait-cycle counters.
module mem_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 32,
  parameter int MAX_HOLD  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_rnw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic              addr_err,
  output logic              mem_en,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic [1:0]        state_dbg
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0]       cpu_wait_cnt,
  output logic [15:0]       host_wait_cnt
`endif
);

  // Handshake: a requester raises req with rnw/addr/wdata stable and keeps them until it sees
  // a one-cycle ack; rdata and addr_err are valid only while that ack is high.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_HOST = 2'b10;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [ADDR_W:0]   MEM_LIM  = (ADDR_W + 1)'(MEM_WORDS);

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic                last_host_q, last_host_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                rnw_q, rnw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                oor_q, oor_d;
  logic                mem_en_q, mem_en_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                host_ack_q, host_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                addr_err_q, addr_err_d;

  logic                grant_cpu, grant_host;
  logic                sel_rnw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W-1:0]   rd_val;

  // Locked host bursts win ties until MAX_HOLD grants have gone by with the CPU waiting.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_host = 1'b0;
    if (state_q == S_IDLE) begin
      if (cpu_req && host_req) begin
        if (host_lock) grant_host = (hold_q < HOLD_LIM);
        else           grant_host = !last_host_q;
        grant_cpu = !grant_host;
      end else begin
        grant_cpu  = cpu_req;
        grant_host = host_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_host_d  = last_host_q;
    hold_d       = hold_q;
    rnw_d        = rnw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    oor_d        = oor_q;
    mem_en_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    addr_err_d   = 1'b0;
    sel_rnw      = grant_host ? host_rnw   : cpu_rnw;
    sel_addr     = grant_host ? host_addr  : cpu_addr;
    sel_wdata    = grant_host ? host_wdata : cpu_wdata;
    rd_val       = (rnw_q && !oor_q) ? mem_rdata : '0;
    case (state_q)
      S_IDLE: begin
        if (grant_cpu || grant_host) begin
          owner_d     = grant_host ? OWN_HOST : OWN_CPU;
          last_host_d = grant_host;
          rnw_d       = sel_rnw;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          oor_d       = ({1'b0, sel_addr} >= MEM_LIM);
          mem_en_d    = !oor_d;
          if (grant_cpu || !cpu_req) hold_d = '0;
          else if (hold_q != HOLD_LIM) hold_d = hold_q + 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (owner_q == OWN_HOST) begin
          host_rdata_d = rd_val;
          host_ack_d   = 1'b1;
        end else begin
          cpu_rdata_d  = rd_val;
          cpu_ack_d    = 1'b1;
        end
        addr_err_d = oor_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      last_host_q  <= 1'b0;
      hold_q       <= '0;
      rnw_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      oor_q        <= 1'b0;
      mem_en_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_host_q  <= last_host_d;
      hold_q       <= hold_d;
      rnw_q        <= rnw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      oor_q        <= oor_d;
      mem_en_q     <= mem_en_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign addr_err   = addr_err_q;
  assign mem_en     = mem_en_q;
  assign mem_rnw    = rnw_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign owner      = owner_q;
  assign state_dbg  = state_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] cpu_wait_q, cpu_wait_d, host_wait_q, host_wait_d;

  // A side is waiting while the other one owns the RAM or is being granted this cycle.
  always_comb begin
    cpu_wait_d  = cpu_wait_q;
    host_wait_d = host_wait_q;
    if (cpu_req && (owner_q == OWN_HOST || grant_host) && cpu_wait_q != 16'hFFFF)
      cpu_wait_d = cpu_wait_q + 16'd1;
    if (host_req && (owner_q == OWN_CPU || grant_cpu) && host_wait_q != 16'hFFFF)
      host_wait_d = host_wait_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_wait_q  <= '0;
      host_wait_q <= '0;
    end else begin
      cpu_wait_q  <= cpu_wait_d;
      host_wait_q <= host_wait_d;
    end
  end

  assign cpu_wait_cnt  = cpu_wait_q;
  assign host_wait_cnt = host_wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MAX_HOLD=4) with a 32-word synchronous RAM model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_rnw, host_req, host_rnw, host_lock;
  logic [15:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic        cpu_ack, host_ack, addr_err, mem_en, mem_rnw;
  logic [15:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  owner, state_dbg;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] cpu_wait_cnt, host_wait_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [15:0] ram [0:31];

  mem_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_rnw(host_rnw), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_lock(host_lock),
    .addr_err(addr_err), .mem_en(mem_en), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner), .state_dbg(state_dbg)
`ifdef MEM_ARBITER_STATS_EN
    , .cpu_wait_cnt(cpu_wait_cnt), .host_wait_cnt(host_wait_cnt)
`endif
  );

  // Clock and RAM model: reset reloads the known contents, reads return one cycle after the strobe.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ram[i] <= 16'h0000;
      ram[5]    <= 16'h1234;
      ram[7]    <= 16'hAAAA;
      ram[9]    <= 16'h5555;
      ram[31]   <= 16'hBEEF;
      mem_rdata <= 16'h0000;
    end else if (mem_en) begin
      if (mem_rnw) mem_rdata <= ram[mem_addr[4:0]];
      else         ram[mem_addr[4:0]] <= mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated access starting in IDLE: ack expected three cycles after the request.
  task automatic single_access(input bit is_host, input bit rnw, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_rdata,
                               input bit exp_err, input string tag);
    logic exp_en;
    exp_en = (addr < 16'd32);
    if (is_host) begin
      host_req = 1'b1; host_rnw = rnw; host_addr = addr; host_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_rnw = rnw; cpu_addr = addr; cpu_wdata = wdata;
    end
    tick();
    chk({tag, "_owner"}, owner, is_host ? 2'b10 : 2'b01);
    chk({tag, "_mem_en"}, mem_en, exp_en);
    tick();
    tick();
    if (is_host) begin
      chk({tag, "_ack"}, host_ack, 1);
      chk({tag, "_rdata"}, host_rdata, exp_rdata);
      chk({tag, "_other_ack"}, cpu_ack, 0);
      host_req = 1'b0;
    end else begin
      chk({tag, "_ack"}, cpu_ack, 1);
      chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
      chk({tag, "_other_ack"}, host_ack, 0);
      cpu_req = 1'b0;
    end
    chk({tag, "_err"}, addr_err, exp_err);
    tick();
    chk({tag, "_owner_idle"}, owner, 0);
  endtask

  logic [3:0]  alt_order;
  logic [11:0] lock_order;
  int hi, ci;

  initial begin
    cpu_rnw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    host_rnw = 1'b1; host_addr = '0; host_wdata = '0;
    do_reset();
    chk("rst_state", state_dbg, 0);
    chk("rst_flags", {cpu_ack, host_ack, mem_en, addr_err, owner}, 0);
    chk("rst_rdata", {cpu_rdata, host_rdata}, 0);

    // CPU read of addr 5: strobe in N+1, ack with data in N+3.
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'd5;
    tick();
    chk("rd5_en", mem_en, 1);
    chk("rd5_addr", mem_addr, 5);
    chk("rd5_rnw", mem_rnw, 1);
    chk("rd5_owner_n1", owner, 1);
    tick();
    chk("rd5_en_n2", mem_en, 0);
    chk("rd5_owner_n2", owner, 1);
    chk("rd5_ack_n2", cpu_ack, 0);
    tick();
    chk("rd5_ack_n3", cpu_ack, 1);
    chk("rd5_rdata", cpu_rdata, 16'h1234);
    chk("rd5_err", addr_err, 0);
    chk("rd5_host_ack", host_ack, 0);
    cpu_req = 1'b0;
    tick();
    chk("rd5_ack_drop", cpu_ack, 0);
    chk("rd5_owner_clr", owner, 0);
    chk("rd5_rdata_hold", cpu_rdata, 16'h1234);

    // Tie on the first cycle after reset, both held: host, cpu, host, cpu.
    do_reset();
    host_req = 1'b1; host_rnw = 1'b1; host_addr = 16'd7;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'd9;
    alt_order = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("alt%0d_owner", k), owner, alt_order[k] ? 2'b10 : 2'b01);
      tick();
      tick();
      if (alt_order[k]) begin
        chk($sformatf("alt%0d_host_ack", k), {host_ack, cpu_ack}, 2'b10);
        chk($sformatf("alt%0d_host_rdata", k), host_rdata, 16'hAAAA);
      end else begin
        chk($sformatf("alt%0d_cpu_ack", k), {host_ack, cpu_ack}, 2'b01);
        chk($sformatf("alt%0d_cpu_rdata", k), cpu_rdata, 16'h5555);
      end
      if (k == 3) begin
        host_req = 1'b0;
        cpu_req = 1'b0;
      end
      tick();
    end

    // Locked host burst of 10 writes with cpu pending: H x4, C, H x4, C, H x2.
    lock_order = 12'b1101_1110_1111;
    hi = 0; ci = 0;
    host_lock = 1'b1;
    host_req = 1'b1; host_rnw = 1'b0; host_addr = 16'd10; host_wdata = 16'h0100;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'd9;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("lock%0d_owner", k), owner, lock_order[k] ? 2'b10 : 2'b01);
      if (lock_order[k]) begin
        chk($sformatf("lock%0d_waddr", k), {mem_en, mem_rnw, mem_addr}, {2'b10, 16'(10 + hi)});
        chk($sformatf("lock%0d_wdata", k), mem_wdata, 16'h0100 + 16'(hi));
      end
      tick();
      tick();
      if (lock_order[k]) begin
        chk($sformatf("lock%0d_host_ack", k), {host_ack, cpu_ack}, 2'b10);
        hi++;
        if (hi == 10) host_req = 1'b0;
        else begin
          host_addr = 16'(10 + hi);
          host_wdata = 16'h0100 + 16'(hi);
        end
      end else begin
        chk($sformatf("lock%0d_cpu_ack", k), {host_ack, cpu_ack}, 2'b01);
        ci++;
        if (ci == 2) cpu_req = 1'b0;
      end
      tick();
    end
    host_lock = 1'b0;
    chk("burst_count", hi, 10);
    chk("ram19_written", ram[19], 16'h0109);

    // Read-back of burst data, then range boundaries.
    single_access(1'b0, 1'b1, 16'd19, 16'h0000, 16'h0109, 1'b0, "cpu_rd19");
    single_access(1'b1, 1'b1, 16'd12, 16'h0000, 16'h0102, 1'b0, "host_rd12");
    single_access(1'b1, 1'b0, 16'd40, 16'hDEAD, 16'h0000, 1'b1, "host_wr40");
    chk("cpu_rdata_kept", cpu_rdata, 16'h0109);
    chk("ram8_untouched", ram[8], 16'h0000);
    single_access(1'b0, 1'b1, 16'd31, 16'h0000, 16'hBEEF, 1'b0, "cpu_rd31");
    single_access(1'b0, 1'b1, 16'd32, 16'h0000, 16'h0000, 1'b1, "cpu_rd32");
    single_access(1'b0, 1'b0, 16'd6, 16'h7777, 16'h0000, 1'b0, "cpu_wr6");
    single_access(1'b1, 1'b1, 16'd6, 16'h0000, 16'h7777, 1'b0, "host_rd6");

    // Reset during WAIT of a cpu read aborts it silently.
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'd5;
    tick();
    tick();
    chk("abort_in_wait", state_dbg, 2);
    rst = 1'b1; cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_no_ack", cpu_ack, 0);
    chk("abort_owner", owner, 0);
    chk("abort_state", state_dbg, 0);
    single_access(1'b1, 1'b1, 16'd7, 16'h0000, 16'hAAAA, 1'b0, "post_rst_rd7");

`ifdef MEM_ARBITER_STATS_EN
    do_reset();
    chk("stats_rst", {cpu_wait_cnt, host_wait_cnt}, 0);
    host_req = 1'b1; host_rnw = 1'b1; host_addr = 16'd7;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'd9;
    tick();
    tick();
    tick();
    host_req = 1'b0;
    tick();
    tick();
    tick();
    tick();
    cpu_req = 1'b0;
    tick();
    chk("stats_cpu_wait", cpu_wait_cnt, 4);
    chk("stats_host_wait", host_wait_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
